// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous clock in clk cycles,
// delivering each completed measurement through a valid/ready handshake.
module clock_period_meter #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_in,
  input  logic             enable,
  input  logic             clear,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  input  logic             ready,
  output logic             edge_pulse,
  output logic             timeout,
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  localparam logic [CNT_W:0] TIMEOUT_V = (CNT_W+1)'(TIMEOUT);

  state_t           state, state_next;
  logic             s1, s2, s3;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] hi_q, hi_next;
  logic [CNT_W:0]   cnt_inc;
  logic             result_load, timeout_set, drop;

  assign rise    = s2 & ~s3;
  assign fall    = ~s2 & s3;
  assign cnt_inc = {1'b0, cnt} + 1'b1;
  assign drop    = valid & ~ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    hi_next     = hi_q;
    result_load = 1'b0;
    timeout_set = 1'b0;
    if (!enable) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_next   = '0;
          state_next = ARM;
        end
        ARM: begin
          if (rise) begin
            cnt_next   = '0;
            hi_next    = '0;
            state_next = MEASURE;
          end
        end
        MEASURE: begin
          cnt_next = cnt_inc[CNT_W-1:0];
          if (fall) hi_next = cnt_inc[CNT_W-1:0];
          // hi_q restarts at every rise so a period without a fall reports 0
          if (rise) begin
            result_load = 1'b1;
            cnt_next    = '0;
            hi_next     = '0;
          end else if (cnt_inc == TIMEOUT_V) begin
            timeout_set = 1'b1;
            cnt_next    = '0;
            state_next  = ARM;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      hi_q       <= '0;
      edge_pulse <= 1'b0;
      timeout    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      hi_q       <= hi_next;
      edge_pulse <= rise;
      timeout    <= timeout_set | (timeout & ~clear);
      overrun    <= (result_load & drop) | (overrun & ~clear);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
    end else if (result_load && !drop) begin
      period    <= cnt_inc[CNT_W-1:0];
      high_time <= hi_q;
      valid     <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clock_period_meter.sv
// Scoreboard bench for clock_period_meter: clk_in is synthesised on clk
// negedges, expected results are queued at each completing rise.
module tb_clock_period_meter;

  logic        clk = 1'b0;
  logic        rst, clk_in, enable, clear, ready;
  logic [15:0] period, high_time;
  logic        valid, edge_pulse, timeout, overrun;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] q[$];
  logic [31:0] exp_res;
  logic        meas, track, ep_prev;
  logic [15:0] last_hi, last_lo;

  clock_period_meter #(.CNT_W(16), .TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .clk_in(clk_in), .enable(enable), .clear(clear),
    .period(period), .high_time(high_time), .valid(valid), .ready(ready),
    .edge_pulse(edge_pulse), .timeout(timeout), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Outputs and ready are stable here; the following posedge uses these values.
  always @(negedge clk) begin
    #1;
    if (valid && ready) begin
      if (q.size() == 0) check("unexpected_result", 32'd1, 32'd0);
      else begin
        exp_res = q.pop_front();
        check("period", {16'd0, period}, {16'd0, exp_res[31:16]});
        check("high_time", {16'd0, high_time}, {16'd0, exp_res[15:0]});
      end
    end
    if (edge_pulse) check("ep_width", {31'd0, ep_prev}, 32'd0);
    ep_prev = edge_pulse;
  end

  task automatic rise_edge();
    if (meas && track) q.push_back({16'(last_hi + last_lo), last_hi});
    meas   = 1'b1;
    clk_in = 1'b1;
  endtask

  task automatic drive_period(input int hi, input int lo);
    rise_edge();
    last_hi = 16'(hi);
    last_lo = 16'(lo);
    repeat (hi) @(negedge clk);
    clk_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic restart();
    enable = 1'b0;
    meas   = 1'b0;
    repeat (3) @(negedge clk);
    enable = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"}, {16'd0, period}, 32'd0);
    check({tag, "_high"}, {16'd0, high_time}, 32'd0);
    check({tag, "_valid"}, {31'd0, valid}, 32'd0);
    check({tag, "_edge"}, {31'd0, edge_pulse}, 32'd0);
    check({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    check({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; clk_in = 1'b0; enable = 1'b0; clear = 1'b0; ready = 1'b0;
    meas = 1'b0; track = 1'b1; ep_prev = 1'b0; last_hi = '0; last_lo = '0;
    repeat (3) @(negedge clk);
    #1 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;
    ready = 1'b1;

    // T1: 16/16
    restart();
    repeat (4) drive_period(16, 16);

    // T2: 3/7 with edge_pulse timing
    restart();
    rise_edge();
    last_hi = 16'd3;
    last_lo = 16'd7;
    @(posedge clk); #1 check("ep_p0", {31'd0, edge_pulse}, 32'd0);
    @(posedge clk); #1 check("ep_p1", {31'd0, edge_pulse}, 32'd0);
    @(posedge clk); #1 check("ep_p2", {31'd0, edge_pulse}, 32'd1);
    @(negedge clk);
    clk_in = 1'b0;
    @(posedge clk); #1 check("ep_p3", {31'd0, edge_pulse}, 32'd0);
    repeat (7) @(negedge clk);
    repeat (4) drive_period(3, 7);

    // T3: back-pressure, overrun, clear
    restart();
    ready = 1'b0;
    drive_period(5, 9);
    drive_period(6, 6);
    track = 1'b0;
    drive_period(4, 8);
    drive_period(7, 3);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("hold_valid", {31'd0, valid}, 32'd1);
    check("hold_period", {16'd0, period}, 32'd14);
    check("hold_high", {16'd0, high_time}, 32'd5);
    check("overrun_set", {31'd0, overrun}, 32'd1);
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    #1;
    check("overrun_clr", {31'd0, overrun}, 32'd0);
    check("valid_after_clr", {31'd0, valid}, 32'd1);
    @(negedge clk);
    track = 1'b1;
    ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 check("valid_drained", {31'd0, valid}, 32'd0);

    // T4: timeout at 100 counts, then recovery
    restart();
    drive_period(10, 80);
    #1 check("timeout_early", {31'd0, timeout}, 32'd0);
    repeat (40) @(negedge clk);
    #1 check("timeout_set", {31'd0, timeout}, 32'd1);
    meas = 1'b0;
    @(negedge clk);
    repeat (4) drive_period(20, 20);
    #1 check("timeout_sticky", {31'd0, timeout}, 32'd1);
    @(negedge clk) clear = 1'b1;
    @(negedge clk) clear = 1'b0;
    #1 check("timeout_clr", {31'd0, timeout}, 32'd0);

    // T5: enable dropped mid-period
    restart();
    repeat (3) drive_period(12, 12);
    rise_edge();
    repeat (6) @(negedge clk);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    clk_in = 1'b0;
    repeat (6) @(negedge clk);
    enable = 1'b1;
    meas = 1'b0;
    repeat (4) @(negedge clk);
    repeat (3) drive_period(12, 12);

    // T6: asynchronous reset with a pending result
    restart();
    ready = 1'b0;
    track = 1'b0;
    drive_period(16, 16);
    drive_period(16, 16);
    #1 check("pre_rst_valid", {31'd0, valid}, 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b1;
    ready = 1'b1;
    track = 1'b1;
    meas = 1'b0;
    repeat (4) @(negedge clk);
    repeat (3) drive_period(16, 16);
    enable = 1'b0;
    repeat (8) @(negedge clk);
    check("sb_empty", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
